// File: rtl/act_lut_loader.sv
`default_nettype none
// ============================================================================
// Module      : act_lut_loader
// Description : Frames a received byte stream (sync byte, 2**ADDR_WIDTH table
//               entries, 8-bit additive checksum) and drives the write port
//               of the activation LUT RAM. lut_valid is raised only after a
//               load whose checksum matched.
// Revision    : 1.0 - initial release
// ============================================================================
module act_lut_loader #(
    parameter int         ADDR_WIDTH  = 11,
    parameter int         DATA_WIDTH  = 8,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_rdy,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  lut_valid
);

    // Idle-clock counter only needs to reach TIMEOUT_CYC-1.
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0]         C_TLIM = TW'(TIMEOUT_CYC - 1);
    // Last entry address; the extra counter bit must be zero here so the
    // exit from LOAD never depends on the counter wrapping.
    localparam logic [ADDR_WIDTH:0]   C_LAST = {1'b0, {ADDR_WIDTH{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SYNC  = 2'd1,
        S_LOAD  = 2'd2,
        S_CHECK = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_WIDTH:0] r_cnt;
    logic [7:0]          r_sum;
    logic [TW-1:0]       r_tcnt;

    logic w_accept;
    logic w_write;
    logic w_pass;
    logic w_fail;
    logic w_tout;

    // Next-state decode and per-cycle event strobes.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_write  = 1'b0;
        w_pass   = 1'b0;
        w_fail   = 1'b0;
        w_tout   = (r_state != S_IDLE) && !rx_rdy && (r_tcnt == C_TLIM);
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_SYNC;
                end
            end
            S_SYNC: begin
                if (rx_rdy && (rx_data == SYNC_BYTE)) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (rx_rdy) begin
                    w_write = 1'b1;
                    if (r_cnt == C_LAST) begin
                        w_next = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (rx_rdy) begin
                    w_pass = (rx_data == r_sum);
                    w_fail = (rx_data != r_sum);
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (w_tout) begin
            w_next = S_IDLE;
        end
    end

    // State register; busy is registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
        end else begin
            r_state <= w_next;
            busy    <= (w_next != S_IDLE);
        end
    end

    // RAM write port: one registered write per data byte in LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= w_write;
            if (w_write) begin
                wr_addr <= r_cnt[ADDR_WIDTH-1:0];
                wr_data <= DATA_WIDTH'(rx_data);
            end
        end
    end

    // Status flags: done pulses, err and lut_valid hold until the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done      <= 1'b0;
            err       <= 1'b0;
            lut_valid <= 1'b0;
        end else begin
            done <= w_pass;
            if (w_accept) begin
                err       <= 1'b0;
                lut_valid <= 1'b0;
            end else begin
                if (w_fail || w_tout) begin
                    err <= 1'b1;
                end
                if (w_pass) begin
                    lut_valid <= 1'b1;
                end
            end
        end
    end

    // Entry counter and running mod-256 checksum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_sum <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_sum <= '0;
        end else if (w_write) begin
            r_cnt <= r_cnt + 1'b1;
            r_sum <= r_sum + rx_data;
        end
    end

    // Idle-clock counter: restarts on every byte and whenever IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tcnt <= '0;
        end else if ((r_state == S_IDLE) || rx_rdy) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end

endmodule
`default_nettype wire
